// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// ps2_host_tx_if : command handshake and PS/2 pad bundle. Rev 1.0
// ------------------------------------------------------------------------
interface ps2_host_tx_if;
  logic [7:0] din;
  logic       tx_req;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       rx_block;
  logic       kbd_clk;
  logic       kbd_dat;
  logic       kbd_clk_low;
  logic       kbd_dat_low;

  modport master (
    output din, tx_req, kbd_clk, kbd_dat,
    input  tx_ready, tx_done, tx_err, rx_block, kbd_clk_low, kbd_dat_low
  );

  modport slave (
    input  din, tx_req, kbd_clk, kbd_dat,
    output tx_ready, tx_done, tx_err, rx_block, kbd_clk_low, kbd_dat_low
  );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ------------------------------------------------------------------------
// ps2_host_tx : PS/2 host-to-device command transmitter with ACK check. Rev 1.0
// ------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         resetN,
  ps2_host_tx_if.slave bus
);
  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  state_t           state_q;
  logic [1:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  logic             clk_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [8:0]       shift_q;
  logic             tx_ready_q;
  logic             tx_done_q;
  logic             tx_err_q;
  logic             rx_block_q;
  logic             clk_low_q;
  logic             dat_low_q;

  logic kbd_fall_d;
  logic timeout_d;

  assign kbd_fall_d = clk_prev_q & ~clk_sync_q[1];
  assign timeout_d  = (cnt_q == TIMEOUT_LAST);

  // Synchronizers reset high so the idle bus never looks like a falling edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      cnt_q      <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 9'd0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      rx_block_q <= 1'b0;
      clk_low_q  <= 1'b0;
      dat_low_q  <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], bus.kbd_clk};
      dat_sync_q <= {dat_sync_q[0], bus.kbd_dat};
      clk_prev_q <= clk_sync_q[1];
      tx_done_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.tx_req) begin
            shift_q    <= {~^bus.din, bus.din};
            cnt_q      <= '0;
            clk_low_q  <= 1'b1;
            tx_ready_q <= 1'b0;
            rx_block_q <= 1'b1;
            state_q    <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q == INHIBIT_LAST) begin
            dat_low_q <= 1'b1;
            state_q   <= S_REQ;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_REQ: begin
          clk_low_q <= 1'b0;
          cnt_q     <= '0;
          bit_cnt_q <= 4'd0;
          state_q   <= S_DATA;
        end
        S_DATA: begin
          if (timeout_d) begin
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            tx_done_q <= 1'b1;
            tx_err_q  <= 1'b1;
            state_q   <= S_FAIL;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if (kbd_fall_d) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              // Tenth edge: release data as the stop bit and await the device ACK.
              if (bit_cnt_q == 4'd9) begin
                dat_low_q <= 1'b0;
                state_q   <= S_ACK;
              end else begin
                dat_low_q <= ~shift_q[0];
                shift_q   <= {1'b0, shift_q[8:1]};
              end
            end
          end
        end
        S_ACK: begin
          if (timeout_d || (kbd_fall_d && dat_sync_q[1])) begin
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            tx_done_q <= 1'b1;
            tx_err_q  <= 1'b1;
            state_q   <= S_FAIL;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if (kbd_fall_d) begin
              state_q <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (timeout_d) begin
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            tx_done_q <= 1'b1;
            tx_err_q  <= 1'b1;
            state_q   <= S_FAIL;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if (clk_sync_q[1] && dat_sync_q[1]) begin
              tx_done_q <= 1'b1;
              tx_err_q  <= 1'b0;
              state_q   <= S_DONE;
            end
          end
        end
        S_DONE, S_FAIL: begin
          tx_err_q   <= 1'b0;
          tx_ready_q <= 1'b1;
          rx_block_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_ready    = tx_ready_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.tx_err      = tx_err_q;
  assign bus.rx_block    = rx_block_q;
  assign bus.kbd_clk_low = clk_low_q;
  assign bus.kbd_dat_low = dat_low_q;
endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_ps2_host_tx : directed bench with a PS/2 device model and scoreboards. Rev 1.0
// ------------------------------------------------------------------------
module tb_ps2_host_tx;
  localparam int INH = 10;
  localparam int TMO = 200;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   d0;
  logic [10:0] exp_frame_q[$];
  logic        exp_err_q[$];

  ps2_host_tx_if bif ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bif.slave)
  );

  always #5 clk = ~clk;

  // Open-drain pads: either side pulling low wins.
  assign bif.kbd_clk = !(bif.kbd_clk_low || dev_clk_low);
  assign bif.kbd_dat = !(bif.kbd_dat_low || dev_dat_low);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bif.tx_ready, bif.tx_done, bif.tx_err, bif.rx_block, bif.kbd_clk_low, bif.kbd_dat_low};
  endfunction

  // Frame as seen by the device: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0), b, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (resetN && bif.tx_done) begin
      n_done++;
      chk("done_pending", 32'(exp_err_q.size() != 0), 1);
      if (exp_err_q.size() != 0) chk("done_err", bif.tx_err, exp_err_q.pop_front());
      @(negedge clk);
      chk("after_done", outs(), 6'b100000);
    end
  end

  task automatic send(input logic [7:0] b, input bit push_frame, input bit expect_done, input bit err);
    @(negedge clk);
    bif.din    = b;
    bif.tx_req = 1'b1;
    if (push_frame) exp_frame_q.push_back(frame_of(b));
    if (expect_done) exp_err_q.push_back(err);
    @(negedge clk);
    bif.tx_req = 1'b0;
    bif.din    = ~b;
    chk("accept", outs(), 6'b000110);
  endtask

  task automatic check_inhibit();
    int n = 0;
    int r = 0;
    while (bif.kbd_clk_low && !bif.kbd_dat_low && n < 10 * INH) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    while (bif.kbd_clk_low && bif.kbd_dat_low && r < 10) begin
      r++;
      @(negedge clk);
    end
    chk("req_len", r, 1);
  endtask

  task automatic device(input bit nack, input bit glitch, input bit abort);
    logic [10:0] got = '0;
    int t = 0;
    while (!(!bif.kbd_clk_low && bif.kbd_dat_low) && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("rts_seen", {bif.kbd_clk_low, bif.kbd_dat_low}, 2'b01);
    repeat (4) @(negedge clk);
    got[0] = bif.kbd_dat;
    for (int k = 1; k <= 10; k++) begin
      if (glitch && k == 4) begin
        bif.din    = 8'h55;
        bif.tx_req = 1'b1;
        @(negedge clk);
        bif.tx_req = 1'b0;
      end
      dev_clk_low = 1'b1;
      repeat (6) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (3) @(negedge clk);
      got[k] = bif.kbd_dat;
      repeat (3) @(negedge clk);
      if (abort && k == 4) begin
        resetN = 1'b0;
        #1;
        chk("reset_async", outs(), 6'b100000);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        return;
      end
    end
    if (!nack) dev_dat_low = 1'b1;
    repeat (3) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (6) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    dev_dat_low = 1'b0;
    chk("frame_pending", 32'(exp_frame_q.size() != 0), 1);
    if (exp_frame_q.size() != 0) chk("frame_bits", got, exp_frame_q.pop_front());
  endtask

  task automatic wait_idle(input int done_before);
    int t = 0;
    while (!bif.tx_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("idle_reached", bif.tx_ready, 1);
    repeat (2) @(negedge clk);
    chk("done_count", n_done - done_before, 1);
  endtask

  initial begin
    int n;
    bif.din    = 8'h00;
    bif.tx_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", outs(), 6'b100000);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    d0 = n_done; send(8'hED, 1, 1, 0); check_inhibit(); device(0, 0, 0); wait_idle(d0);
    d0 = n_done; send(8'h00, 1, 1, 0); check_inhibit(); device(0, 0, 0); wait_idle(d0);
    d0 = n_done; send(8'hF4, 1, 1, 0); check_inhibit(); device(0, 0, 0); wait_idle(d0);
    d0 = n_done; send(8'h12, 1, 1, 1); check_inhibit(); device(1, 0, 0); wait_idle(d0);
    d0 = n_done; send(8'hA3, 1, 1, 0); check_inhibit(); device(0, 1, 0); wait_idle(d0);

    // Device never clocks: the frame must fail after exactly TMO cycles in START.
    d0 = n_done; send(8'hA5, 0, 1, 1); check_inhibit();
    n = 0;
    while (!bif.kbd_clk_low && bif.kbd_dat_low && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_len", n, TMO);
    wait_idle(d0);

    d0 = n_done; send(8'h3C, 0, 0, 0); check_inhibit(); device(0, 0, 1);
    repeat (20) @(negedge clk);
    chk("no_done_on_reset", n_done - d0, 0);
    d0 = n_done; send(8'hFF, 1, 1, 0); check_inhibit(); device(0, 0, 0); wait_idle(d0);

    chk("queues_empty", exp_err_q.size() + exp_frame_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the same open-drain clock/data pair the keyboard receiver listens on. It performs the inhibit/request-to-send sequence, shifts out 8 data bits LSB-first plus odd parity and stop, and checks the device ACK. It sits beside the keyboard receiver in the keyboard subsystem and masks that receiver while a host frame is on the wire.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000: clk cycles kbd_clk is held low before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles from clock release to frame end (20 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- din  in  8  command byte, sampled when tx_req is accepted.
- tx_req  in  1  send request; accepted only while tx_ready=1.
- tx_ready  out  1  high in IDLE only.
- tx_done  out  1  one-cycle pulse at end of every accepted transfer (success or failure).
- tx_err  out  1  valid with tx_done: 1 = NACK or timeout.
- rx_block  out  1  high whenever not IDLE; gates the keyboard receiver.
- kbd_clk  in  1  PS/2 clock line (raw pad).
- kbd_dat  in  1  PS/2 data line (raw pad).
- kbd_clk_low  out  1  1 = drive PS/2 clock low, 0 = release.
- kbd_dat_low  out  1  1 = drive PS/2 data low, 0 = release.

## Operation
- kbd_clk, kbd_dat pass through 2-flop synchronizers; falling edge = previous synced clk 1, current 0.
- All outputs registered. Reset values: tx_ready=1, all other outputs 0; counters and shift register cleared.
- Frame shift register, 9 bits: {parity, din}, parity = ~^din (odd).
- States:
  - IDLE: lines released. tx_req=1 -> latch din, load shift register, clear counter -> INHIBIT.
  - INHIBIT: kbd_clk_low=1. After INHIBIT_CYCLES cycles -> REQ.
  - REQ: kbd_clk_low=1, kbd_dat_low=1, one cycle -> START (clear timeout counter, bit counter=0).
  - START/DATA: kbd_clk_low=0. kbd_dat_low = start bit (1) until first falling edge. On each falling edge, bit counter increments:
    - edges 1–8: kbd_dat_low = ~din[edge-1];
    - edge 9: kbd_dat_low = ~parity;
    - edge 10: kbd_dat_low=0 (stop = released) -> ACK.
  - ACK: on next falling edge (11th) sample synced kbd_dat: 0 = ACK -> WAIT_IDLE; 1 = NACK -> FAIL.
  - WAIT_IDLE: wait until synced kbd_clk=1 and kbd_dat=1 -> DONE.
  - DONE: tx_done=1, tx_err=0 for one cycle -> IDLE.
  - FAIL: release both lines, tx_done=1, tx_err=1 for one cycle -> IDLE.
- Timeout: counter runs from START through WAIT_IDLE; reaching TIMEOUT_CYCLES in any of these -> FAIL. Timeout counter is shared with the inhibit counter; width = $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1).
- tx_req outside IDLE is ignored, not queued. din changes after acceptance have no effect.
- Host frame aborts any keyboard transmission in progress (protocol-legal); the receiver is masked by rx_block.
- Reset mid-frame: both lines released asynchronously, FSM to IDLE, no tx_done.

## Timing
- tx_req high at edge N (IDLE): kbd_clk_low=1, tx_ready=0, rx_block=1 from edge N+1.
- kbd_clk_low stays high for INHIBIT_CYCLES cycles, then REQ for 1 cycle with both low, then clock released, data held low.
- Data bit update: 1 cycle after synchronized falling edge detection (3 clk cycles after pad edge max), well inside the ≥30 µs PS/2 low phase.
- tx_done pulse is 1 cycle; tx_ready returns 1 the cycle after tx_done.
- Device latency is external; worst-case transfer = INHIBIT_CYCLES + 1 + TIMEOUT_CYCLES + 3 cycles.

## Test plan
- Send 0xED with ACKing device model -> device samples start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done=1, tx_err=0; kbd_clk_low high exactly INHIBIT_CYCLES cycles.
- Send 0x00 and 0xF4 -> parity bits 1 and 0 respectively; both complete with tx_err=0.
- Device leaves data high on 11th clock (NACK) -> tx_done=1, tx_err=1, both lines released, tx_ready=1 next cycle.
- INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, device never clocks -> FAIL after 200 cycles in START, tx_err=1.
- tx_req pulsed during DATA with different din -> ignored; frame carries the original byte, single tx_done.
- resetN low after 4th data bit -> kbd_clk_low=kbd_dat_low=0 immediately, tx_ready=1, no tx_done; new 0xFF request afterwards completes normally.
